// File: rtl/rs232_rx.sv
// rs232_rx: 8N1 serial receiver, 16x oversampled with 3-sample majority vote.
// Ports: clk_50mhz/rst_n, rx_tick, rx -> wr_clk/wr_en/dout to rx FIFO, full,
//        frame_err and overrun 1-clock status pulses.
module rs232_rx #(
    parameter int OS_RATE  = 16,
    parameter int SYNC_STG = 2
) (
    input  logic       clk_50mhz,
    input  logic       rst_n,
    input  logic       rx_tick,
    input  logic       rx,
    output logic       wr_clk,
    output logic       wr_en,
    output logic [7:0] dout,
    input  logic       full,
    output logic       frame_err,
    output logic       overrun
);

    localparam int CW = $clog2(OS_RATE);
    localparam int M  = OS_RATE / 2;
    localparam logic [CW-1:0] C_LO  = CW'(M - 1);
    localparam logic [CW-1:0] C_MID = CW'(M);
    localparam logic [CW-1:0] C_HI  = CW'(M + 1);
    localparam logic [CW-1:0] C_TOP = CW'(OS_RATE - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BRK
    } state_t;

    logic [SYNC_STG-1:0] r_sync;
    state_t              r_state;
    logic [CW-1:0]       r_os_cnt;
    logic [2:0]          r_bit_cnt;
    logic [7:0]          r_shift;
    logic                r_s0;
    logic                r_s1;
    logic                r_armed;
    logic                r_wr_en;
    logic [7:0]          r_dout;
    logic                r_frame_err;
    logic                r_overrun;

    state_t        w_state;
    logic [CW-1:0] w_os_cnt;
    logic [CW-1:0] w_os_inc;
    logic [2:0]    w_bit_cnt;
    logic [7:0]    w_shift;
    logic          w_armed;
    logic          w_wr_en;
    logic [7:0]    w_dout;
    logic          w_frame_err;
    logic          w_overrun;
    logic          w_rxs;
    logic          w_vote;
    logic          w_dec;

    assign wr_clk    = clk_50mhz;
    assign wr_en     = r_wr_en;
    assign dout      = r_dout;
    assign frame_err = r_frame_err;
    assign overrun   = r_overrun;

    assign w_rxs    = r_sync[SYNC_STG-1];
    assign w_vote   = (r_s0 & r_s1) | (r_s0 & w_rxs) | (r_s1 & w_rxs);
    assign w_dec    = rx_tick && (r_os_cnt == C_HI);
    assign w_os_inc = (r_os_cnt == C_TOP) ? '0 : r_os_cnt + 1'b1;

    always_comb begin
        w_state     = r_state;
        w_os_cnt    = r_os_cnt;
        w_bit_cnt   = r_bit_cnt;
        w_shift     = r_shift;
        w_armed     = r_armed;
        w_wr_en     = 1'b0;
        w_dout      = r_dout;
        w_frame_err = 1'b0;
        w_overrun   = 1'b0;
        if (rx_tick) begin
            unique case (r_state)
                S_IDLE: begin
                    // A start edge is only accepted once the line was seen high.
                    if (w_rxs) begin
                        w_armed = 1'b1;
                    end else if (r_armed) begin
                        w_state  = S_START;
                        w_os_cnt = '0;
                        w_armed  = 1'b0;
                    end
                end
                S_START: begin
                    w_os_cnt = w_os_inc;
                    if (w_dec) begin
                        if (!w_vote) begin
                            w_state   = S_DATA;
                            w_bit_cnt = '0;
                        end else begin
                            w_state = S_IDLE;
                        end
                    end
                end
                S_DATA: begin
                    w_os_cnt = w_os_inc;
                    if (w_dec) begin
                        w_shift   = {w_vote, r_shift[7:1]};
                        w_bit_cnt = r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7) begin
                            w_state = S_STOP;
                        end
                    end
                end
                S_STOP: begin
                    w_os_cnt = w_os_inc;
                    if (w_dec) begin
                        if (w_vote) begin
                            // Leave at mid-stop so an early start edge is caught.
                            w_state = S_IDLE;
                            w_armed = 1'b1;
                            if (full) begin
                                w_overrun = 1'b1;
                            end else begin
                                w_wr_en = 1'b1;
                                w_dout  = r_shift;
                            end
                        end else begin
                            w_state     = S_BRK;
                            w_frame_err = 1'b1;
                        end
                    end
                end
                S_BRK: begin
                    if (w_rxs) begin
                        w_state = S_IDLE;
                        w_armed = 1'b1;
                    end
                end
                default: begin
                    w_state = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_50mhz or negedge rst_n) begin
        if (!rst_n) begin
            r_sync      <= '1;
            r_state     <= S_IDLE;
            r_os_cnt    <= '0;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_s0        <= 1'b1;
            r_s1        <= 1'b1;
            r_armed     <= 1'b0;
            r_wr_en     <= 1'b0;
            r_dout      <= '0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_sync      <= {r_sync[SYNC_STG-2:0], rx};
            r_state     <= w_state;
            r_os_cnt    <= w_os_cnt;
            r_bit_cnt   <= w_bit_cnt;
            r_shift     <= w_shift;
            r_armed     <= w_armed;
            r_wr_en     <= w_wr_en;
            r_dout      <= w_dout;
            r_frame_err <= w_frame_err;
            r_overrun   <= w_overrun;
            if (rx_tick && r_os_cnt == C_LO) begin
                r_s0 <= w_rxs;
            end
            if (rx_tick && r_os_cnt == C_MID) begin
                r_s1 <= w_rxs;
            end
        end
    end

endmodule

// File: tb/tb_rs232_rx.sv
// tb_rs232_rx: directed bench for rs232_rx with a byte scoreboard.
// Drives 8N1 frames at ~115200 baud from a 16x tick and checks FIFO writes/flags.
module tb_rs232_rx;

    localparam int TDIV = 27;

    logic       clk_50mhz = 1'b0;
    logic       rst_n     = 1'b0;
    logic       rx        = 1'b1;
    logic       full      = 1'b0;
    logic       rx_tick;
    logic       wr_clk;
    logic       wr_en;
    logic [7:0] dout;
    logic       frame_err;
    logic       overrun;

    int n_pass  = 0;
    int n_total = 0;
    int wr_cnt  = 0;
    int fe_cnt  = 0;
    int ov_cnt  = 0;
    int tdiv    = 0;
    logic prev_wr = 1'b0;
    logic [7:0] exp_q[$];

    rs232_rx #(.OS_RATE(16), .SYNC_STG(2)) dut (
        .clk_50mhz(clk_50mhz),
        .rst_n    (rst_n),
        .rx_tick  (rx_tick),
        .rx       (rx),
        .wr_clk   (wr_clk),
        .wr_en    (wr_en),
        .dout     (dout),
        .full     (full),
        .frame_err(frame_err),
        .overrun  (overrun)
    );

    always #10 clk_50mhz = ~clk_50mhz;

    always @(posedge clk_50mhz) begin
        tdiv <= (tdiv == TDIV - 1) ? 0 : tdiv + 1;
    end
    assign rx_tick = (tdiv == TDIV - 1);

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    endtask

    always @(negedge clk_50mhz) begin
        if (rst_n) begin
            if (wr_en) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_wr", {24'd0, dout}, 32'hFFFF_FFFF);
                end else begin
                    chk("dout", {24'd0, dout}, {24'd0, exp_q.pop_front()});
                end
                chk("wr_width", {31'd0, prev_wr}, 0);
                wr_cnt++;
            end
            if (wr_en | frame_err | overrun) begin
                chk("excl", 32'(wr_en) + 32'(frame_err) + 32'(overrun), 1);
            end
            if (frame_err) fe_cnt++;
            if (overrun) ov_cnt++;
            prev_wr = wr_en;
        end
    end

    task automatic wait_ticks(input int n);
        int k = 0;
        while (k < n) begin
            @(negedge clk_50mhz);
            if (rx_tick) k++;
        end
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        wait_ticks(16);
    endtask

    task automatic send_byte(input logic [7:0] d, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(stop);
    endtask

    task automatic chk_counts(input string tag, input int w, input int f,
                              input int o);
        chk({tag, "_wr"}, wr_cnt, w);
        chk({tag, "_fe"}, fe_cnt, f);
        chk({tag, "_ov"}, ov_cnt, o);
    endtask

    initial begin
        logic [7:0] b5a;
        b5a = 8'h5A;
        repeat (5) @(negedge clk_50mhz);
        chk("rst_wr", {31'd0, wr_en}, 0);
        chk("rst_dout", {24'd0, dout}, 0);
        chk("rst_fe", {31'd0, frame_err}, 0);
        chk("rst_ov", {31'd0, overrun}, 0);
        rst_n = 1'b1;

        wait_ticks(1000);
        chk_counts("idle", 0, 0, 0);

        exp_q.push_back(8'hA5);
        send_byte(8'hA5, 1'b1);
        exp_q.push_back(8'h3C);
        send_byte(8'h3C, 1'b1);
        wait_ticks(4);
        chk_counts("two", 2, 0, 0);

        rx = 1'b0;
        wait_ticks(5);
        rx = 1'b1;
        wait_ticks(32);
        chk_counts("glitch", 2, 0, 0);
        exp_q.push_back(8'h55);
        send_byte(8'h55, 1'b1);
        wait_ticks(4);
        chk_counts("after_glitch", 3, 0, 0);

        send_byte(8'h81, 1'b0);
        wait_ticks(320);
        rx = 1'b1;
        wait_ticks(32);
        chk_counts("break", 3, 1, 0);
        exp_q.push_back(8'h42);
        send_byte(8'h42, 1'b1);
        wait_ticks(4);
        chk_counts("after_break", 4, 1, 0);

        full = 1'b1;
        send_byte(8'hFF, 1'b1);
        full = 1'b0;
        wait_ticks(4);
        chk_counts("overrun", 4, 1, 1);
        exp_q.push_back(8'h00);
        send_byte(8'h00, 1'b1);
        wait_ticks(4);
        chk_counts("after_ovr", 5, 1, 1);

        exp_q.push_back(8'h5A);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) begin
            if (i == 3) begin
                rx = 1'b1;
                wait_ticks(8);
                rx = 1'b0;
                wait_ticks(1);
                rx = 1'b1;
                wait_ticks(7);
            end else begin
                send_bit(b5a[i]);
            end
        end
        send_bit(1'b1);
        wait_ticks(4);
        chk_counts("spike", 6, 1, 1);

        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        wait_ticks(5);
        rst_n = 1'b0;
        #1;
        chk("arst_wr", {31'd0, wr_en}, 0);
        chk("arst_dout", {24'd0, dout}, 0);
        chk("arst_fe", {31'd0, frame_err}, 0);
        chk("arst_ov", {31'd0, overrun}, 0);
        rx = 1'b1;
        repeat (10) @(negedge clk_50mhz);
        rst_n = 1'b1;
        wait_ticks(64);
        chk_counts("arst", 6, 1, 1);
        exp_q.push_back(8'h96);
        send_byte(8'h96, 1'b1);
        wait_ticks(4);
        chk_counts("recover", 7, 1, 1);
        chk("q_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
